// File: rtl/fwd_pkg.sv
// fwd_pkg: shared select codes, result kinds and stage record for the hazard/forwarding controller
package fwd_pkg;

    localparam logic [2:0] SEL_RF    = 3'd0;
    localparam logic [2:0] SEL_WD    = 3'd1;
    localparam logic [2:0] SEL_AO_M  = 3'd2;
    localparam logic [2:0] SEL_LO_M  = 3'd3;
    localparam logic [2:0] SEL_HI_M  = 3'd4;
    localparam logic [2:0] SEL_PC8_M = 3'd5;
    localparam logic [2:0] SEL_PC8_E = 3'd6;

    localparam logic [2:0] KIND_ALU = 3'd0;
    localparam logic [2:0] KIND_HI  = 3'd1;
    localparam logic [2:0] KIND_LO  = 3'd2;
    localparam logic [2:0] KIND_PC8 = 3'd3;
    localparam logic [2:0] KIND_DM  = 3'd4;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    // One in-flight instruction; md_div only matters when md_start is set.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [2:0] kind;
        logic       md_start;
        logic       md_div;
    } stage_t;

    // Select code for a ready result sitting in M.
    function automatic logic [2:0] m_sel(logic [2:0] kind);
        return kind == KIND_ALU ? SEL_AO_M :
               kind == KIND_HI  ? SEL_HI_M :
               kind == KIND_LO  ? SEL_LO_M :
               kind == KIND_PC8 ? SEL_PC8_M : SEL_RF;
    endfunction

    // Operand r is needed in tuse cycles but E or M produces it later than that.
    function automatic logic op_late(logic [4:0] r, logic [1:0] tuse, stage_t e, stage_t m);
        return r != 5'd0 && tuse != TUSE_NONE &&
               ((r == e.dst && e.tnew > tuse) || (r == m.dst && m.tnew > tuse));
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: priority forwarding select for one operand
//   reg_i      operand register number
//   e_i/m_i/w_i stage records, youngest first (E ignored when USE_E = 0)
//   sel_o      forwarding mux select code
module fwd_sel
    import fwd_pkg::*;
#(
    parameter bit USE_E = 1'b1
) (
    input  logic [4:0] reg_i,
    input  stage_t     e_i,
    input  stage_t     m_i,
    input  stage_t     w_i,
    output logic [2:0] sel_o
);

    logic hit_e, hit_m, hit_w;
    logic unused_rec;

    assign hit_e = USE_E && reg_i == e_i.dst;
    assign hit_m = reg_i == m_i.dst;
    assign hit_w = reg_i == w_i.dst;
    assign unused_rec = ^{e_i, m_i, w_i};

    // The youngest matching stage wins; if its result is not ready yet the
    // select falls back to the register value and the stall logic holds D.
    // Every result exists by W, so a W match always forwards WD.
    always_comb
        sel_o = reg_i == 5'd0 ? SEL_RF :
                hit_e ? (e_i.tnew == 2'd0 && e_i.kind == KIND_PC8 ? SEL_PC8_E : SEL_RF) :
                hit_m ? (m_i.tnew == 2'd0 ? m_sel(m_i.kind) : SEL_RF) :
                hit_w ? SEL_WD : SEL_RF;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: stall and forwarding-select control for the 5-stage pipeline
//   clk, reset                      clock, synchronous active-high reset
//   rs_D, rt_D, tuse_rs_D, tuse_rt_D operands of the D instruction and when they are consumed
//   dst_D, tnew_D, kind_D           result register, latency from E entry and source kind
//   md_start_D, md_is_div_D, md_use_D mult/div start, divide flag, HI/LO access
//   stall                           freeze F/D and bubble E
//   f_rs_d, f_rt_d, f_rs_e, f_rt_e  D- and E-stage forwarding selects
//   f_rt_m                          M-stage store-data select (1 = WD)
//   md_busy                         mult/div unit busy
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic [4:0] dst_D,
    input  logic [1:0] tnew_D,
    input  logic [2:0] kind_D,
    input  logic       md_start_D,
    input  logic       md_is_div_D,
    input  logic       md_use_D,
    output logic       stall,
    output logic [2:0] f_rs_d,
    output logic [2:0] f_rt_d,
    output logic [2:0] f_rs_e,
    output logic [2:0] f_rt_e,
    output logic       f_rt_m,
    output logic       md_busy
);

    stage_t e_q, m_q, w_q, e_d, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic stall_rs, stall_rt, stall_md;

    assign stall_rs = op_late(rs_D, tuse_rs_D, e_q, m_q);
    assign stall_rt = op_late(rt_D, tuse_rt_D, e_q, m_q);
    // A mult/div still in E has not loaded the counter yet but already owns HI/LO.
    assign stall_md = md_use_D & (md_busy | e_q.md_start);
    assign stall    = stall_rs | stall_rt | stall_md;

    assign md_busy = cnt_q != '0;
    assign f_rt_m  = m_q.rt != 5'd0 && m_q.rt == w_q.dst;

    always_comb begin
        e_d = stall ? '0 : stage_t'{rs: rs_D, rt: rt_D, dst: dst_D, tnew: tnew_D,
                                    kind: kind_D, md_start: md_start_D,
                                    md_div: md_start_D & md_is_div_D};
        m_d = e_q;
        m_d.tnew = e_q.tnew == 2'd0 ? 2'd0 : e_q.tnew - 2'd1;
        cnt_d = e_q.md_start ? (e_q.md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)) :
                md_busy ? cnt_q - CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= m_q;
            cnt_q <= cnt_d;
        end
    end

    fwd_sel #(.USE_E(1'b1)) u_rs_d (.reg_i(rs_D),   .e_i(e_q), .m_i(m_q), .w_i(w_q), .sel_o(f_rs_d));
    fwd_sel #(.USE_E(1'b1)) u_rt_d (.reg_i(rt_D),   .e_i(e_q), .m_i(m_q), .w_i(w_q), .sel_o(f_rt_d));
    fwd_sel #(.USE_E(1'b0)) u_rs_e (.reg_i(e_q.rs), .e_i(e_q), .m_i(m_q), .w_i(w_q), .sel_o(f_rs_e));
    fwd_sel #(.USE_E(1'b0)) u_rt_e (.reg_i(e_q.rt), .e_i(e_q), .m_i(m_q), .w_i(w_q), .sel_o(f_rt_e));

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage MIPS pipeline.
- Tracks the destination register, remaining-latency count (Tnew) and result kind of every in-flight instruction across the E, M and W stages.
- Drives the select codes of the D/E/M forwarding muxes and the pipeline stall.
- Owns the mult/div busy counter that interlocks HI/LO accesses.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issues from E.
- DIV_CYCLES, 10, busy cycles after a div/divu issues from E.
- CNT_W, 4, width of the busy counter; must hold DIV_CYCLES.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous active-high reset.
- rs_D  in  5  rs field of the instruction in D.
- rt_D  in  5  rt field of the instruction in D.
- tuse_rs_D  in  2  cycles until rs is consumed (0/1/2); 3 = rs unused.
- tuse_rt_D  in  2  same encoding, for rt.
- dst_D  in  5  register written by the D instruction; 0 = none.
- tnew_D  in  2  cycles from E entry until the result exists.
- kind_D  in  3  result source: 0 ALU (AO), 1 HI, 2 LO, 3 PC8, 4 DM/other.
- md_start_D  in  1  D instruction is mult/multu/div/divu.
- md_is_div_D  in  1  qualifies md_start_D.
- md_use_D  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div.
- stall  out  1  freeze PC and the F/D register; bubble E.
- f_rs_d  out  3  select code for the D-stage rs mux.
- f_rt_d  out  3  select code for the D-stage rt mux.
- f_rs_e  out  3  select code for the E-stage rs mux.
- f_rt_e  out  3  select code for the E-stage rt mux.
- f_rt_m  out  1  select for the M-stage store data: 1 = WD, 0 = pipelined value.
- md_busy  out  1  mult/div unit busy.

Behaviour:
- Select encoding (fixed): 0 register/pipelined value, 1 WD, 2 AO_M, 3 LO_M, 4 HI_M, 5 PC8_M, 6 PC8_E.
- Internal stage records E, M and W. Each record holds rs, rt, dst, tnew, kind and md_start.
- Each clk:
  - W <= M.
  - M <= E, with tnew decremented and saturating at 0.
  - E <= D fields with tnew as given, or a bubble (all fields 0) when stall=1.
- Reset clears all records and the busy counter. After reset all outputs are 0.
- stall is combinational.
  - stall_rs asserts if rs_D != 0, tuse_rs_D != 3, and either:
    - rs_D == E.dst and E.tnew > tuse_rs_D, or
    - rs_D == M.dst and M.tnew > tuse_rs_D.
  - stall_rt is the same check for rt.
  - stall_md = md_use_D & (md_busy | E.md_start).
  - stall = stall_rs | stall_rt | stall_md.
- D-stage select (f_rs_d; f_rt_d is identical with rt), reg = rs_D:
  - reg == 0 -> 0.
  - Else, in priority order, pick the first matching stage whose tnew == 0:
    - E match with kind PC8 -> 6.
    - M match -> kind ALU 2, HI 4, LO 3, PC8 5.
    - W match -> 1.
  - Otherwise 0.
  - A match with tnew > 0 in a younger stage blocks older stages; the select is then 0 and stall covers the case.
- E-stage select: same rules with reg = E.rs/E.rt, sources M then W. Code 6 is never produced.
- f_rt_m = (M.rt != 0 & M.rt == W.dst).
- Busy counter:
  - Loaded with MULT_CYCLES or DIV_CYCLES when an E record with md_start advances to M.
  - Decrements each cycle while non-zero.
  - md_busy = (count != 0).
  - Reset mid-count clears it immediately.
- Simultaneous events:
  - A stall on the same cycle as a busy load still inserts the bubble.
  - The counter load proceeds.

Decomposition:
- Package fwd_pkg holds:
  - select-code localparams (SEL_RF … SEL_PC8_E);
  - kind codes;
  - TUSE_NONE = 3;
  - the stage-record struct.
- One sub-module, fwd_sel, is natural: the combinational priority select for one operand, instantiated 4 times with the stage list as a parameter.

Test Plan:
- addu $1 writes, next addu reads $1 in E (tuse 1) -> no stall; f_rs_e=2 on the following cycle; next-next reader gets f_rs_e=1.
- lw $2 (tnew 2, kind DM) then beq on $2 (tuse 0) -> stall=1 for 2 cycles, then f_rs_d=1.
- jal (dst 31, tnew 0, kind PC8) then jr $31 -> f_rs_d=6 with no stall; one cycle later the select is 5.
- mult issues, then mflo in D -> stall for 1 (E.md_start) + 5 cycles; md_busy drops, then mflo forwards.
- div; reset asserted at busy cycle 3 -> md_busy=0 and stall=0 on the next cycle.
- sw $3 in M, with $3 written by the instruction in W -> f_rt_m=1; rt=0 -> f_rt_m=0.
